mem_status_rr_arbiter: RTL and testbench
========================================

# mem_status_rr_arbiter

Round-robin arbiter that merges `NUM_PORTS` independent memory-status streams, for example per-channel DMA or TCP memory write-status returns, onto one status stream. The merged stream leaves through a single registered output stage that also carries the index of the winning source. It sits upstream of the status register slices, so several memory clients can share one status consumer without starvation.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requester streams; legal range 1–16.
- `WIDTH`, 8: status word width in bits, matching the `axis_mem_status` data width.
- `SRC_W`, max(1, $clog2(NUM_PORTS)): width of the source index (derived; do not override).

Ports:
- `aclk`  in  1  clock; all logic is in this single domain.
- `aresetn`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  NUM_PORTS  per-port status valid.
- `s_ready`  out  NUM_PORTS  per-port ready; at most one bit is high per cycle.
- `s_data`  in  NUM_PORTS*WIDTH  port i occupies bits [i*WIDTH +: WIDTH].
- `m_axis`  `axis_mem_status.master`  WIDTH  merged output (valid/ready/data).
- `m_src`  out  SRC_W  index of the port that produced the word on `m_axis.data`; valid while `m_axis.valid` is high.

## Operation
- Output register: a one-entry holding stage with a `full` flag that drives `m_axis.valid`, plus data and source fields.
- `load = !full || m_axis.ready`, meaning the stage is empty or drains in this cycle.
- Arbitration runs only when `load` is true. It scans ports starting at `(last+1) mod NUM_PORTS`, wraps, and grants the first port with `s_valid` high.
- `s_ready[g] = load && s_valid[g]` for the granted port `g` only. All other bits are 0.
- On grant (`s_valid[g] && s_ready[g]`):
  - the register loads `s_data[g]` and `m_src = g`, and `full` is set;
  - `last` is set to `g`.
- No grant while draining (`m_axis.valid && m_axis.ready`, with no requester valid): `full` clears.
- `last` updates only on an accepted transfer. An idle cycle does not move the priority.
- A granted port that holds `s_valid` with its data unchanged is accepted in the same cycle. `s_valid` may never be withdrawn before acceptance.
- `NUM_PORTS == 1`: the block degenerates to a full-throughput register slice with `m_src` fixed at 0.
- Data is passed through unmodified; no width conversion.

## Timing
- Reset values (asynchronous, immediate on `aresetn` low):
  - `m_axis.valid` = 0, `m_axis.data` = 0, `m_src` = 0;
  - `last = NUM_PORTS-1`, so port 0 has first priority after reset;
  - `s_ready` = all 0 while `aresetn` is low.
- Latency: a word accepted on input at edge N appears with `m_axis.valid` high after edge N, and can be consumed at edge N+1.
- Throughput: one word per cycle when `m_axis.ready` is held high.
- Combinational paths: `m_axis.ready` → `s_ready` and `s_valid` → `s_ready` (ready depends on valid, which is AXI-Stream legal). There is no path from any input to `m_axis.valid`, `m_axis.data` or `m_src`.
- Backpressure: while `full && !m_axis.ready`, all `s_ready` are 0 and `m_axis.data`/`m_src` stay stable.
- Fairness: with all ports continuously valid and the output never stalled, the grant sequence is 0,1,…,NUM_PORTS-1,0,… Any port waits at most NUM_PORTS-1 accepted transfers.
- Simultaneous drain and load: both occur in the same edge, `full` stays 1, and no bubble is inserted.
- Reset mid-operation: a word held in the register is discarded. Upstream ports must re-present it after reset.

## Test plan
1. **Reset defaults.** Assert `aresetn`=0 mid-stream with `full`=1. Require `m_axis.valid`=0, `m_src`=0 and `s_ready`=0 immediately. After release with all ports valid, the first grant is port 0.
2. **Full-rate rotation.** Set `NUM_PORTS`=4, port i sends data 0x10+i continuously, `m_axis.ready`=1. Require output 0x10,0x11,0x12,0x13,0x10,… with `m_src` 0,1,2,3,0 and one word every cycle after the first.
3. **Backpressure hold.** With `full`=1 showing data 0x12/src 2, drop `m_axis.ready` for 5 cycles. Require data and src stable, all `s_ready`=0, and rotation resuming with port 3 after ready returns.
4. **Sparse requesters.** Only ports 1 and 3 are valid, `last`=3. Require grants 1,3,1,3 with no grant to idle ports and no extra bubbles.
5. **Priority hold on idle.** Grant port 2, then 3 idle cycles with no valid, then ports 0 and 3 both valid. Require port 3 granted first (`last`=2 unchanged during idle).
6. **Single port.** With `NUM_PORTS`=1, send 8 words 0x00–0x07 under random `m_axis.ready`. Require in-order, lossless, duplicate-free output with `m_src`=0.

Source files
------------

// File: rtl/mem_status_rr_arbiter_if.sv
// Status-stream bundle (valid/ready/data) shared by memory-status producers
// and consumers. The master drives valid and data, and the slave drives ready.
interface axis_mem_status #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/mem_status_rr_arbiter.sv
// Round-robin merge of NUM_PORTS memory-status streams onto one registered
// output stage. The stage also carries the index of the winning source.
// Priority rotates only on accepted transfers, so an idle cycle keeps the
// current order.
module mem_status_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8,
  parameter int SRC_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_PORTS-1:0]       s_valid,
  output logic [NUM_PORTS-1:0]       s_ready,
  input  logic [NUM_PORTS*WIDTH-1:0] s_data,
  axis_mem_status.master             m_axis,
  output logic [SRC_W-1:0]           m_src
);

  // Output holding stage and round-robin pointer
  logic             full_reg,  full_next;
  logic [WIDTH-1:0] data_reg,  data_next;
  logic [SRC_W-1:0] src_reg,   src_next;
  logic [SRC_W-1:0] last_reg,  last_next;

  // Arbitration helpers
  logic                 load;
  logic                 accept;
  logic [NUM_PORTS-1:0] hi_mask;
  logic [NUM_PORTS-1:0] req_hi;
  logic [NUM_PORTS-1:0] grant_oh;

  // AND-OR mux chains that turn the one-hot grant into data and index
  logic [WIDTH-1:0] data_chain [NUM_PORTS+1];
  logic [SRC_W-1:0] src_chain  [NUM_PORTS+1];

  assign data_chain[0] = '0;
  assign src_chain[0]  = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      // Ports strictly above the last winner get first look in the scan.
      assign hi_mask[gi] = (SRC_W'(gi) > last_reg);

      assign data_chain[gi+1] = data_chain[gi]
                              | ({WIDTH{grant_oh[gi]}} & s_data[gi*WIDTH +: WIDTH]);
      assign src_chain[gi+1]  = src_chain[gi]
                              | (grant_oh[gi] ? SRC_W'(gi) : '0);
    end
  endgenerate

  // The stage can take a new word when it is empty or drains this cycle.
  assign load = !full_reg || m_axis.ready;

  // Rotating priority pick. Take the lowest requester above `last`.
  // Otherwise wrap around and take the lowest requester overall.
  // x & -x isolates the lowest set bit.
  always_comb begin
    req_hi   = s_valid & hi_mask;
    grant_oh = '0;
    if (|req_hi) begin
      grant_oh = req_hi & (-req_hi);
    end else begin
      grant_oh = s_valid & (-s_valid);
    end
  end

  // Only the granted port sees ready, and only while reset is released.
  always_comb begin
    s_ready = '0;
    if (aresetn && load) begin
      s_ready = grant_oh;
    end
  end

  assign accept = |s_ready;

  // Next-state for the holding stage. A load wins over a drain, so a
  // simultaneous drain and load keeps the stage full without a bubble.
  always_comb begin
    full_next = full_reg;
    data_next = data_reg;
    src_next  = src_reg;
    last_next = last_reg;
    if (accept) begin
      full_next = 1'b1;
      data_next = data_chain[NUM_PORTS];
      src_next  = src_chain[NUM_PORTS];
      last_next = src_chain[NUM_PORTS];
    end else if (m_axis.ready) begin
      full_next = 1'b0;
    end
  end

  // State registers. Reset points `last` at the top port so port 0 goes first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_reg <= 1'b0;
      data_reg <= '0;
      src_reg  <= '0;
      last_reg <= SRC_W'(NUM_PORTS - 1);
    end else begin
      full_reg <= full_next;
      data_reg <= data_next;
      src_reg  <= src_next;
      last_reg <= last_next;
    end
  end

  assign m_axis.valid = full_reg;
  assign m_axis.data  = data_reg;
  assign m_src        = src_reg;

endmodule

// File: tb/tb_mem_status_rr_arbiter.sv
// Directed checks for the round-robin status arbiter. A 4-port instance
// covers reset, rotation, backpressure, sparse requesters and priority hold.
// A 1-port instance covers the degenerate register-slice case.
module tb_mem_status_rr_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic [3:0]  sv4;
    logic [3:0]  sr4;
    logic [31:0] sd4;
    logic [1:0]  src4;

    logic        sv1;
    logic        sr1;
    logic [7:0]  sd1;
    logic [0:0]  src1;

    int checks = 0;
    int errors = 0;

    axis_mem_status #(.WIDTH(8)) m4 ();
    axis_mem_status #(.WIDTH(8)) m1 ();

    mem_status_rr_arbiter #(.NUM_PORTS(4), .WIDTH(8)) dut4 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sv4),
        .s_ready (sr4),
        .s_data  (sd4),
        .m_axis  (m4.master),
        .m_src   (src4)
    );

    mem_status_rr_arbiter #(.NUM_PORTS(1), .WIDTH(8)) dut1 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sv1),
        .s_ready (sr1),
        .s_data  (sd1),
        .m_axis  (m1.master),
        .m_src   (src1)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_data;
    logic [1:0] exp_src;
    logic [3:0] exp_rdy;
    int         sent;
    int         rx;
    logic       exp_r1;

    initial begin
        aresetn  = 1'b0;
        sv4      = 4'b1111;
        sd4      = {8'h13, 8'h12, 8'h11, 8'h10};
        m4.ready = 1'b0;
        sv1      = 1'b0;
        sd1      = 8'h00;
        m1.ready = 1'b0;
        #3;
        report("rst_valid", m4.valid, 1'b0, m4.valid === 1'b0);
        report("rst_src", src4, 2'd0, src4 === 2'd0);
        report("rst_sready", sr4, 4'b0000, sr4 === 4'b0000);
        report("rst_valid1", m1.valid, 1'b0, m1.valid === 1'b0);

        tick();
        aresetn  = 1'b1;
        m4.ready = 1'b1;
        #1;
        report("first_grant", sr4, 4'b0001, sr4 === 4'b0001);

        for (int k = 0; k < 11; k++) begin
            tick();
            exp_src  = 2'(k % 4);
            exp_data = 8'h10 + 8'(k % 4);
            exp_rdy  = 4'b0001 << ((k + 1) % 4);
            report("rot_valid", m4.valid, 1'b1, m4.valid === 1'b1);
            report("rot_data", m4.data, exp_data, m4.data === exp_data);
            report("rot_src", src4, exp_src, src4 === exp_src);
            report("rot_sready", sr4, exp_rdy, sr4 === exp_rdy);
        end

        m4.ready = 1'b0;
        #1;
        report("bp_sready_now", sr4, 4'b0000, sr4 === 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            report("bp_valid", m4.valid, 1'b1, m4.valid === 1'b1);
            report("bp_data", m4.data, 8'h12, m4.data === 8'h12);
            report("bp_src", src4, 2'd2, src4 === 2'd2);
            report("bp_sready", sr4, 4'b0000, sr4 === 4'b0000);
        end
        m4.ready = 1'b1;
        #1;
        report("bp_resume_grant", sr4, 4'b1000, sr4 === 4'b1000);
        tick();
        report("bp_resume_src", src4, 2'd3, src4 === 2'd3);
        report("bp_resume_data", m4.data, 8'h13, m4.data === 8'h13);

        aresetn = 1'b0;
        #1;
        report("mid_rst_valid", m4.valid, 1'b0, m4.valid === 1'b0);
        report("mid_rst_data", m4.data, 8'h00, m4.data === 8'h00);
        report("mid_rst_src", src4, 2'd0, src4 === 2'd0);
        report("mid_rst_sready", sr4, 4'b0000, sr4 === 4'b0000);
        tick();
        aresetn = 1'b1;
        #1;
        report("post_rst_grant", sr4, 4'b0001, sr4 === 4'b0001);
        tick();
        report("post_rst_src", src4, 2'd0, src4 === 2'd0);
        report("post_rst_data", m4.data, 8'h10, m4.data === 8'h10);

        sv4 = 4'b1000;
        #1;
        report("sparse_setup_grant", sr4, 4'b1000, sr4 === 4'b1000);
        tick();
        report("sparse_setup_src", src4, 2'd3, src4 === 2'd3);
        sv4 = 4'b1010;
        #1;
        report("sparse_first_grant", sr4, 4'b0010, sr4 === 4'b0010);
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_src  = (j % 2 == 1) ? 2'd3 : 2'd1;
            exp_data = (j % 2 == 1) ? 8'h13 : 8'h11;
            exp_rdy  = (j % 2 == 1) ? 4'b0010 : 4'b1000;
            report("sparse_valid", m4.valid, 1'b1, m4.valid === 1'b1);
            report("sparse_src", src4, exp_src, src4 === exp_src);
            report("sparse_data", m4.data, exp_data, m4.data === exp_data);
            report("sparse_sready", sr4, exp_rdy, sr4 === exp_rdy);
        end

        sv4 = 4'b0100;
        #1;
        report("hold_grant2", sr4, 4'b0100, sr4 === 4'b0100);
        tick();
        report("hold_src2", src4, 2'd2, src4 === 2'd2);
        sv4 = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            tick();
            report("idle_valid", m4.valid, 1'b0, m4.valid === 1'b0);
            report("idle_sready", sr4, 4'b0000, sr4 === 4'b0000);
        end
        sv4 = 4'b1001;
        #1;
        report("hold_next_grant", sr4, 4'b1000, sr4 === 4'b1000);
        tick();
        report("hold_src3", src4, 2'd3, src4 === 2'd3);
        report("hold_data3", m4.data, 8'h13, m4.data === 8'h13);
        report("hold_then_grant0", sr4, 4'b0001, sr4 === 4'b0001);
        tick();
        report("hold_src0", src4, 2'd0, src4 === 2'd0);
        report("hold_data0", m4.data, 8'h10, m4.data === 8'h10);
        sv4 = 4'b0000;

        sent = 0;
        rx   = 0;
        for (int cyc = 0; cyc < 400 && rx < 8; cyc++) begin
            tick();
            sv1      = (sent < 8);
            sd1      = 8'(sent);
            m1.ready = 1'($urandom_range(0, 1));
            #1;
            exp_r1 = sv1 && (!m1.valid || m1.ready);
            report("sp_sready", sr1, exp_r1, sr1 === exp_r1);
            if (m1.valid && m1.ready) begin
                report("sp_data", m1.data, 8'(rx), m1.data === 8'(rx));
                report("sp_src", src1, 1'b0, src1 === 1'b0);
                rx++;
            end
            if (sv1 && sr1) sent++;
        end
        report("sp_count", rx, 8, rx === 8);
        tick();
        sv1      = 1'b0;
        m1.ready = 1'b1;
        #1;
        report("sp_drained", m1.valid, 1'b0, m1.valid === 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
